fmlarb_sched: RTL and testbench



---
 rtl/fmlarb_pkg.sv | 16 +
 rtl/fmlarb_rr.sv | 30 +++
 rtl/fmlarb_sched.sv | 146 ++++++++++++++
 tb/tb_fmlarb_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmlarb_pkg.sv
// Shared FML constants and scheduler state encoding for the fmlarb_sched block.
package fmlarb_pkg;

    localparam int FML_BURST = 4;
    localparam int FML_DW    = 64;
    localparam int FML_SEL_W = 8;
    localparam int BEAT_W    = $clog2(FML_BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_BURST = 2'd3
    } arb_state_e;

endpackage

// File: rtl/fmlarb_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module fmlarb_rr
    import fmlarb_pkg::*;
#(
    parameter int NM    = 4,
    parameter int IDX_W = 2
) (
    input  logic [NM-1:0]    req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt,
    output logic             valid
);

    // Scan from the farthest offset down so the closest requester to ptr wins last.
    always_comb begin : pick
        int idx;
        idx   = 0;
        gnt   = ptr;
        valid = 1'b0;
        for (int i = NM - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NM) idx = idx - NM;
            if (req[idx]) begin
                gnt   = IDX_W'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmlarb_sched.sv
// Round-robin scheduler sharing one FML slave port among NM masters, with
// early-ack to delayed master-ack conversion and grant held through the burst.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | no owner; pick next requester from the rr pointer
// ST_REQ   | owner's strobe forwarded to slave, waiting for s_eack
// ST_WAIT  | strobe masked, latency down-counter running (skipped if lat==1)
// ST_BURST | 4 beats; beat 0 carries m_ack, owner's wdata/sel muxed if write
module fmlarb_sched
    import fmlarb_pkg::*;
#(
    parameter int ADR_W      = 26,
    parameter int NM         = 4,
    parameter int RD_ACK_LAT = 4,
    parameter int WR_ACK_LAT = 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NM*ADR_W-1:0]     m_adr,
    input  logic [NM-1:0]           m_stb,
    input  logic [NM-1:0]           m_we,
    input  logic [NM*FML_SEL_W-1:0] m_sel,
    input  logic [NM*FML_DW-1:0]    m_dw,
    output logic [NM-1:0]           m_ack,
    output logic [FML_DW-1:0]       m_dr,
    output logic [ADR_W-1:0]        s_adr,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [FML_SEL_W-1:0]    s_sel,
    output logic [FML_DW-1:0]       s_dw,
    input  logic                    s_eack,
    input  logic [FML_DW-1:0]       s_dr
);

    localparam int IDX_W   = $clog2(NM);
    localparam int LAT_MAX = (RD_ACK_LAT > WR_ACK_LAT) ? RD_ACK_LAT : WR_ACK_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    logic [IDX_W-1:0]     rr_gnt;
    logic                 rr_valid;
    logic [CNT_W-1:0]     lat_ld;
    logic [ADR_W-1:0]     adr_a [NM];
    logic [FML_SEL_W-1:0] sel_a [NM];
    logic [FML_DW-1:0]    dw_a  [NM];

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            adr_a[i] = m_adr[i*ADR_W +: ADR_W];
            sel_a[i] = m_sel[i*FML_SEL_W +: FML_SEL_W];
            dw_a[i]  = m_dw[i*FML_DW +: FML_DW];
        end
    end

    fmlarb_rr #(
        .NM    (NM),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (m_stb),
        .ptr   (ptr_q),
        .gnt   (rr_gnt),
        .valid (rr_valid)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        lat_ld  = m_we[owner_q] ? CNT_W'(WR_ACK_LAT) : CNT_W'(RD_ACK_LAT);
        case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    owner_d = rr_gnt;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!m_stb[owner_q]) begin
                    state_d = ST_IDLE;
                end else if (s_eack) begin
                    we_d    = m_we[owner_q];
                    cnt_d   = lat_ld;
                    beat_d  = '0;
                    // A latency of 1 means the very next cycle is the ack beat.
                    state_d = (lat_ld == CNT_W'(1)) ? ST_BURST : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(2)) state_d = ST_BURST;
            end
            ST_BURST: begin
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(FML_BURST - 1)) begin
                    ptr_d   = (owner_q == IDX_W'(NM - 1)) ? '0 : owner_q + IDX_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        m_ack = '0;
        if (state_q == ST_BURST && beat_q == '0) m_ack[owner_q] = 1'b1;
        s_stb = (state_q == ST_REQ) && m_stb[owner_q];
        case (state_q)
            ST_REQ:            s_we = m_we[owner_q];
            ST_WAIT, ST_BURST: s_we = we_q;
            default:           s_we = 1'b0;
        endcase
        s_sel = (state_q == ST_BURST && we_q) ? sel_a[owner_q] : '0;
        s_adr = adr_a[owner_q];
        s_dw  = dw_a[owner_q];
        m_dr  = s_dr;
    end

endmodule

// File: tb/tb_fmlarb_sched.sv
// Self-checking bench for fmlarb_sched: directed scenarios plus randomized traffic
// against a transaction-level round-robin model; a second instance sweeps latencies.
module tb_fmlarb_sched;

    localparam int NM = 4;
    localparam int AW = 26;
    localparam int RD = 4;
    localparam int WR = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NM*AW-1:0] m_adr = '0;
    logic [NM-1:0]    m_stb = '0;
    logic [NM-1:0]    m_we = '0;
    logic [NM*8-1:0]  m_sel = '0;
    logic [NM*64-1:0] m_dw = '0;
    logic [NM-1:0]    m_ack;
    logic [63:0]      m_dr;
    logic [AW-1:0]    s_adr;
    logic             s_stb, s_we;
    logic [7:0]       s_sel;
    logic [63:0]      s_dw;
    logic             s_eack = 1'b0;
    logic [63:0]      s_dr = '0;

    logic [NM*AW-1:0] b_m_adr = '0;
    logic [NM-1:0]    b_m_stb = '0;
    logic [NM-1:0]    b_m_we = '0;
    logic [NM*8-1:0]  b_m_sel = '0;
    logic [NM*64-1:0] b_m_dw = '0;
    logic [NM-1:0]    b_m_ack;
    logic [63:0]      b_m_dr;
    logic [AW-1:0]    b_s_adr;
    logic             b_s_stb, b_s_we;
    logic [7:0]       b_s_sel;
    logic [63:0]      b_s_dw;
    logic             b_s_eack = 1'b0;
    logic [63:0]      b_s_dr = '0;

    fmlarb_sched #(.ADR_W(AW), .NM(NM), .RD_ACK_LAT(RD), .WR_ACK_LAT(WR)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .m_adr(m_adr), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_dw(m_dw),
        .m_ack(m_ack), .m_dr(m_dr),
        .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_dw(s_dw),
        .s_eack(s_eack), .s_dr(s_dr)
    );

    fmlarb_sched #(.ADR_W(AW), .NM(NM), .RD_ACK_LAT(5), .WR_ACK_LAT(2)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .m_adr(b_m_adr), .m_stb(b_m_stb), .m_we(b_m_we), .m_sel(b_m_sel), .m_dw(b_m_dw),
        .m_ack(b_m_ack), .m_dr(b_m_dr),
        .s_adr(b_s_adr), .s_stb(b_s_stb), .s_we(b_s_we), .s_sel(b_s_sel), .s_dw(b_s_dw),
        .s_eack(b_s_eack), .s_dr(b_s_dr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: pending requests per master and the rr pointer.
    logic [AW-1:0] adr_m [NM];
    bit            we_m  [NM];
    logic [7:0]    sel_m [NM];
    logic [63:0]   dat_m [NM][4];
    bit            pend  [NM];
    int            ptr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NM-1:0] onehot(input int e);
        logic [NM-1:0] v;
        v = '0;
        v[e] = 1'b1;
        return v;
    endfunction

    function automatic int pick();
        for (int i = 0; i < NM; i++) begin
            if (pend[(ptr + i) % NM]) return (ptr + i) % NM;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < NM; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic new_req(input int i, input bit we, input logic [AW-1:0] adr, input logic [7:0] sel);
        adr_m[i] = adr;
        we_m[i]  = we;
        sel_m[i] = sel;
        for (int b = 0; b < 4; b++) dat_m[i][b] = {$urandom, $urandom};
        pend[i] = 1'b1;
        m_adr[i*AW +: AW] = adr;
        m_we[i]           = we;
        m_sel[i*8 +: 8]   = sel;
        m_dw[i*64 +: 64]  = dat_m[i][0];
        m_stb[i]          = 1'b1;
    endtask

    // Entered with the DUT idle and pending strobes driven; returns in the idle cycle after.
    task automatic serve_one(input bit abandon, input int d, input int add_m);
        int e;
        int lat;
        int b;
        logic [63:0] dr_v;
        e = pick();
        step();
        #1;
        chk("req_stb", 64'(s_stb), 64'd1);
        chk("req_adr", 64'(s_adr), 64'(adr_m[e]));
        chk("req_we", 64'(s_we), 64'(we_m[e]));
        chk("req_ack", 64'(m_ack), 64'd0);
        for (int i = 0; i < d; i++) begin
            step();
            #1;
            chk("hold_stb", 64'(s_stb), 64'd1);
            chk("hold_ack", 64'(m_ack), 64'd0);
        end
        if (abandon) begin
            m_stb[e] = 1'b0;
            #1;
            chk("abn_stb", 64'(s_stb), 64'd0);
            step();
            #1;
            chk("abn_idle_stb", 64'(s_stb), 64'd0);
            chk("abn_ack", 64'(m_ack), 64'd0);
            m_stb[e] = 1'b1;
            return;
        end
        s_eack = 1'b1;
        if (add_m >= 0 && !pend[add_m]) new_req(add_m, 1'($urandom), AW'($urandom), 8'($urandom));
        lat = we_m[e] ? WR : RD;
        for (int k = 1; k <= lat + 3; k++) begin
            step();
            s_eack = 1'b0;
            b = k - lat;
            dr_v = {$urandom, $urandom};
            s_dr = dr_v;
            if (b >= 0) m_dw[e*64 +: 64] = dat_m[e][b];
            #1;
            chk("ack", 64'(m_ack), (k == lat) ? 64'(onehot(e)) : 64'd0);
            chk("wait_stb", 64'(s_stb), 64'd0);
            chk("dr", m_dr, dr_v);
            if (b >= 0) begin
                chk("burst_dw", s_dw, dat_m[e][b]);
                chk("burst_sel", 64'(s_sel), we_m[e] ? 64'(sel_m[e]) : 64'd0);
            end else begin
                chk("wait_sel", 64'(s_sel), 64'd0);
            end
            if (k == lat) begin
                pend[e]  = 1'b0;
                m_stb[e] = 1'b0;
            end
        end
        step();
        #1;
        chk("end_stb", 64'(s_stb), 64'd0);
        chk("end_sel", 64'(s_sel), 64'd0);
        chk("end_ack", 64'(m_ack), 64'd0);
        ptr = (e + 1) % NM;
    endtask

    task automatic b_lat(input int m, input bit we);
        int n;
        logic [63:0] w;
        w = {$urandom, $urandom};
        b_m_adr[m*AW +: AW] = AW'($urandom);
        b_m_we[m]           = we;
        b_m_sel[m*8 +: 8]   = 8'hA5;
        b_m_dw[m*64 +: 64]  = w;
        b_m_stb[m]          = 1'b1;
        step();
        #1;
        chk("b_req_stb", 64'(b_s_stb), 64'd1);
        chk("b_req_adr", 64'(b_s_adr), 64'(b_m_adr[m*AW +: AW]));
        chk("b_req_we", 64'(b_s_we), 64'(we));
        chk("b_req_dw", b_s_dw, w);
        b_s_eack = 1'b1;
        step();
        b_s_eack = 1'b0;
        #1;
        n = 1;
        while (b_m_ack == '0 && n < 12) begin
            step();
            #1;
            n++;
        end
        chk("b_lat", 64'(n), we ? 64'd2 : 64'd5);
        chk("b_ack", 64'(b_m_ack), 64'(onehot(m)));
        chk("b_sel", 64'(b_s_sel), we ? 64'hA5 : 64'd0);
        b_s_dr = {$urandom, $urandom};
        #1;
        chk("b_dr", b_m_dr, b_s_dr);
        b_m_stb[m] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #1;
        chk("b_end_stb", 64'(b_s_stb), 64'd0);
        chk("b_end_sel", 64'(b_s_sel), 64'd0);
        chk("b_end_ack", 64'(b_m_ack), 64'd0);
    endtask

    initial begin
        int mask;
        for (int i = 0; i < NM; i++) pend[i] = 1'b0;
        m_adr = {$urandom, $urandom, $urandom, $urandom};
        #2;
        chk("rst_ack", 64'(m_ack), 64'd0);
        chk("rst_stb", 64'(s_stb), 64'd0);
        chk("rst_we", 64'(s_we), 64'd0);
        chk("rst_sel", 64'(s_sel), 64'd0);
        chk("rst_adr", 64'(s_adr), 64'(m_adr[AW-1:0]));
        step();
        step();
        rst_n = 1'b1;
        step();

        // Read by master 1, eack after two hold cycles.
        new_req(1, 1'b0, 26'h0001000, 8'h00);
        serve_one(1'b0, 2, -1);

        // Write by master 2, all byte lanes.
        new_req(2, 1'b1, 26'h0002040, 8'hFF);
        serve_one(1'b0, 1, -1);

        // Reset two cycles into the read latency window.
        new_req(1, 1'b0, 26'h0003000, 8'h00);
        step();
        #1;
        chk("rw_req_stb", 64'(s_stb), 64'd1);
        s_eack = 1'b1;
        step();
        s_eack = 1'b0;
        step();
        m_stb[1] = 1'b0;
        pend[1]  = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rw_ack", 64'(m_ack), 64'd0);
        chk("rw_stb", 64'(s_stb), 64'd0);
        chk("rw_we", 64'(s_we), 64'd0);
        chk("rw_sel", 64'(s_sel), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        ptr   = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            #1;
            chk("rw_no_late_ack", 64'(m_ack), 64'd0);
            chk("rw_idle_stb", 64'(s_stb), 64'd0);
        end

        // All four request from pointer 0; master 0 re-requests after its grant.
        for (int i = 0; i < NM; i++) new_req(i, 1'($urandom), AW'($urandom), 8'($urandom));
        serve_one(1'b0, 0, -1);
        new_req(0, 1'b0, AW'($urandom), 8'h00);
        for (int g = 0; g < 4; g++) serve_one(1'b0, 1, -1);

        // Master 3 abandons, re-requests, and is still served before master 0.
        new_req(0, 1'b0, AW'($urandom), 8'h00);
        new_req(3, 1'b1, AW'($urandom), 8'h3C);
        serve_one(1'b1, 1, -1);
        serve_one(1'b0, 0, -1);
        chk("abn_then_other", 64'(pend[0]), 64'd1);
        serve_one(1'b0, 0, -1);

        // Randomized traffic against the model.
        for (int r = 0; r < 40; r++) begin
            if (!any_pend()) begin
                mask = $urandom_range(1, 15);
                for (int i = 0; i < NM; i++)
                    if (mask[i]) new_req(i, 1'($urandom), AW'($urandom), 8'($urandom));
            end
            serve_one($urandom_range(0, 6) == 0, $urandom_range(0, 3),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(0, NM - 1) : -1);
        end
        for (int r = 0; r < 16 && any_pend(); r++) serve_one(1'b0, 1, -1);

        // Latency sweep instance.
        b_lat(1, 1'b0);
        b_lat(3, 1'b1);
        b_lat(0, 1'b0);
        b_lat(2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
